// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, 3x3 window out.
//   master : pixel source / window consumer (drives pix_*, observes window)
//   slave  : the window generator itself
//   pix_valid/pix_sof/pix_in : raster pixel stream, no backpressure
//   px11..px33               : registered window, pxRC = row R (1 oldest), col C (1 leftmost)
//   start/frame_done/sof_err : single-cycle strobes
//   ctr_row/ctr_col          : coordinates of the window centre px22
interface sobel_window_gen_if #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic              pix_valid;
    logic              pix_sof;
    logic [DATA_W-1:0] pix_in;
    logic [DATA_W-1:0] px11, px12, px13;
    logic [DATA_W-1:0] px21, px22, px23;
    logic [DATA_W-1:0] px31, px32, px33;
    logic              start;
    logic [RW-1:0]     ctr_row;
    logic [CW-1:0]     ctr_col;
    logic              frame_done;
    logic              sof_err;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  px11, px12, px13, px21, px22, px23, px31, px32, px33,
        input  start, ctr_row, ctr_col, frame_done, sof_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output px11, px12, px13, px21, px22, px23, px31, px32, px33,
        output start, ctr_row, ctr_col, frame_done, sof_err
    );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-to-3x3-window front end for the Sobel stage.
// Buffers the two previous lines and shifts a 3x3 window on every accepted
// pixel; start pulses one cycle after a pixel that completes a fully
// populated window (row >= 2, col >= 2). No border padding.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : sobel_window_gen_if.slave (pixel stream in, window/strobes out)
module sobel_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
) (
    input  logic                clk,
    input  logic                reset,
    sobel_window_gen_if.slave   bus
);

    logic [CW-1:0]     col_q, col_d, col_eff;
    logic [RW-1:0]     row_q, row_d, row_eff;
    logic              last_col, last_row, win_hit;
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] win_q [3][3];   // [row][col], index 0 = oldest/leftmost
    logic              start_q, frame_done_q, sof_err_q;
    logic [RW-1:0]     ctr_row_q;
    logic [CW-1:0]     ctr_col_q;

    // pix_sof makes the current pixel (0,0) regardless of counter state.
    always_comb begin
        col_eff  = bus.pix_sof ? '0 : col_q;
        row_eff  = bus.pix_sof ? '0 : row_q;
        last_col = (col_eff == CW'(IMG_W - 1));
        last_row = (row_eff == RW'(IMG_H - 1));
        win_hit  = bus.pix_valid && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
        lb1_rd   = lb1_q[col_eff];
        lb2_rd   = lb2_q[col_eff];
        col_d    = col_q;
        row_d    = row_q;
        if (bus.pix_valid) begin
            col_d = last_col ? '0 : col_eff + CW'(1);
            if (last_col)
                row_d = last_row ? '0 : row_eff + RW'(1);
            else
                row_d = row_eff;
        end
    end

    // Line buffers are never reset: a location is always rewritten before
    // its contents can reach an emitted window.
    always_ff @(posedge clk) begin
        if (reset && bus.pix_valid) begin
            lb2_q[col_eff] <= lb1_rd;
            lb1_q[col_eff] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            ctr_row_q    <= '0;
            ctr_col_q    <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            start_q      <= win_hit;
            frame_done_q <= win_hit && last_col && last_row;
            sof_err_q    <= bus.pix_valid && bus.pix_sof && ((col_q != '0) || (row_q != '0));
            if (bus.pix_valid) begin
                // Shift on every accept, even for partial windows, so the
                // window is already filled when the line reaches col 2.
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= bus.pix_in;
            end
            if (win_hit) begin
                ctr_row_q <= row_eff - RW'(1);
                ctr_col_q <= col_eff - CW'(1);
            end
        end
    end

    assign bus.px11       = win_q[0][0];
    assign bus.px12       = win_q[0][1];
    assign bus.px13       = win_q[0][2];
    assign bus.px21       = win_q[1][0];
    assign bus.px22       = win_q[1][1];
    assign bus.px23       = win_q[1][2];
    assign bus.px31       = win_q[2][0];
    assign bus.px32       = win_q[2][1];
    assign bus.px33       = win_q[2][2];
    assign bus.start      = start_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sof_err    = sof_err_q;
    assign bus.ctr_row    = ctr_row_q;
    assign bus.ctr_col    = ctr_col_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    sobel_window_gen_if #(.DATA_W(16), .IMG_W(W), .IMG_H(H)) bus ();

    sobel_window_gen #(.DATA_W(16), .IMG_W(W), .IMG_H(H)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] pxa [9];
    assign pxa[0] = bus.px11; assign pxa[1] = bus.px12; assign pxa[2] = bus.px13;
    assign pxa[3] = bus.px21; assign pxa[4] = bus.px22; assign pxa[5] = bus.px23;
    assign pxa[6] = bus.px31; assign pxa[7] = bus.px32; assign pxa[8] = bus.px33;

    function automatic logic [15:0] pv(input int off, input int r, input int c);
        return 16'(off + 16 * r + c);
    endfunction

    // Applies one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic v, input logic s, input logic [15:0] d);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 9; k++) begin
            tests++;
            if (pxa[k] !== 16'h0) begin fails++; $display("FAIL reset_px k=%0d got %h exp 0", k, pxa[k]); end
        end
        tests++;
        if ({bus.start, bus.frame_done, bus.sof_err, bus.ctr_row, bus.ctr_col} !== 8'h0) begin
            fails++;
            $display("FAIL reset_ctl got st=%b fd=%b err=%b row=%0d col=%0d exp all 0",
                     bus.start, bus.frame_done, bus.sof_err, bus.ctr_row, bus.ctr_col);
        end
        reset = 1'b1;
    endtask

    // Scenario 1 (gap=0) and scenario 2 (gap=1: 3 idle cycles after every second pixel).
    task automatic test_frame(input bit gap);
        int starts = 0, fds = 0, idx = 0;
        bit last_win = 0;
        int lr = 0, lc = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                bit win = (r >= 2) && (c >= 2);
                drive(1'b1, (r == 0) && (c == 0), pv(0, r, c));
                tests++;
                if (bus.start !== win || bus.sof_err !== 1'b0) begin
                    fails++; $display("FAIL frame%0d_start r=%0d c=%0d got st=%b err=%b exp st=%b err=0", gap, r, c, bus.start, bus.sof_err, win);
                end
                tests++;
                if (bus.frame_done !== (r == H-1 && c == W-1)) begin
                    fails++; $display("FAIL frame%0d_fd r=%0d c=%0d got %b", gap, r, c, bus.frame_done);
                end
                if (win) begin
                    tests++;
                    if (bus.ctr_row !== 2'(r-1) || bus.ctr_col !== 3'(c-1)) begin
                        fails++; $display("FAIL frame%0d_ctr got (%0d,%0d) exp (%0d,%0d)", gap, bus.ctr_row, bus.ctr_col, r-1, c-1);
                    end
                    for (int k = 0; k < 9; k++) begin
                        tests++;
                        if (pxa[k] !== pv(0, r-2+k/3, c-2+k%3)) begin
                            fails++; $display("FAIL frame%0d_win r=%0d c=%0d k=%0d got %h exp %h", gap, r, c, k, pxa[k], pv(0, r-2+k/3, c-2+k%3));
                        end
                    end
                end
                starts += bus.start ? 1 : 0;
                fds    += bus.frame_done ? 1 : 0;
                last_win = win; lr = r; lc = c;
                if (gap && (idx % 2 == 1)) begin
                    for (int g = 0; g < 3; g++) begin
                        drive(1'b0, 1'b0, 16'hDEAD);
                        tests++;
                        if (bus.start !== 1'b0 || bus.frame_done !== 1'b0) begin
                            fails++; $display("FAIL gap_strobe got st=%b fd=%b exp 0", bus.start, bus.frame_done);
                        end
                        if (last_win) begin
                            tests++;
                            if (bus.px11 !== pv(0, lr-2, lc-2) || bus.px33 !== pv(0, lr, lc)) begin
                                fails++; $display("FAIL gap_hold got px11=%h px33=%h exp %h %h", bus.px11, bus.px33, pv(0, lr-2, lc-2), pv(0, lr, lc));
                            end
                        end
                    end
                end
                idx++;
            end
        end
        tests++;
        if (starts != 6 || fds != 1) begin
            fails++; $display("FAIL frame%0d_count got starts=%0d fd=%0d exp 6 1", gap, starts, fds);
        end
    endtask

    task automatic test_back_to_back();
        int starts = 0, fds = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    drive(1'b1, (f == 0) && (r == 0) && (c == 0), pv(f * 16'h80, r, c));
                    if (r >= 2 && c >= 2) begin
                        for (int k = 0; k < 9; k++) begin
                            tests++;
                            if (pxa[k] !== pv(f * 16'h80, r-2+k/3, c-2+k%3)) begin
                                fails++; $display("FAIL b2b_win f=%0d r=%0d c=%0d k=%0d got %h exp %h", f, r, c, k, pxa[k], pv(f * 16'h80, r-2+k/3, c-2+k%3));
                            end
                        end
                    end
                    starts += bus.start ? 1 : 0;
                    fds    += bus.frame_done ? 1 : 0;
                end
            end
        end
        tests++;
        if (starts != 12 || fds != 2) begin
            fails++; $display("FAIL b2b_count got starts=%0d fd=%0d exp 12 2", starts, fds);
        end
    endtask

    task automatic test_sof_restart();
        int errs = 0;
        for (int i = 0; i <= 12; i++) begin
            drive(1'b1, 1'b0, pv(0, i / W, i % W));
            errs += bus.sof_err ? 1 : 0;
        end
        tests++;
        if (bus.start !== 1'b1) begin fails++; $display("FAIL sof_pre_start got %b exp 1", bus.start); end
        // pix_sof lands on raster position (2,3); it restarts the frame.
        for (int i = 0; i < W * H; i++) begin
            int r = i / W, c = i % W;
            drive(1'b1, i == 0, pv(16'h40, r, c));
            errs += bus.sof_err ? 1 : 0;
            tests++;
            if (bus.sof_err !== (i == 0) || bus.start !== (r >= 2 && c >= 2)) begin
                fails++; $display("FAIL sof_strobe i=%0d got err=%b st=%b exp err=%b st=%b", i, bus.sof_err, bus.start, i == 0, r >= 2 && c >= 2);
            end
            if (r == 2 && c == 2) begin
                tests++;
                if (bus.ctr_row !== 2'd1 || bus.ctr_col !== 3'd1 || bus.px11 !== 16'h40 || bus.px33 !== 16'h62) begin
                    fails++; $display("FAIL sof_first_win got ctr=(%0d,%0d) px11=%h px33=%h exp (1,1) 0040 0062", bus.ctr_row, bus.ctr_col, bus.px11, bus.px33);
                end
            end
        end
        tests++;
        if (errs != 1) begin fails++; $display("FAIL sof_err_count got %0d exp 1", errs); end
    endtask

    task automatic test_mid_reset();
        int errs = 0, starts = 0;
        for (int i = 0; i <= 16; i++) drive(1'b1, 1'b0, pv(0, i / W, i % W));
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tests++;
            if (pxa[k] !== 16'h0) begin fails++; $display("FAIL midrst_px k=%0d got %h exp 0", k, pxa[k]); end
        end
        tests++;
        if ({bus.start, bus.frame_done, bus.sof_err, bus.ctr_row, bus.ctr_col} !== 8'h0) begin
            fails++; $display("FAIL midrst_ctl got st=%b fd=%b err=%b row=%0d col=%0d exp 0", bus.start, bus.frame_done, bus.sof_err, bus.ctr_row, bus.ctr_col);
        end
        for (int i = 0; i < W * H; i++) begin
            int r = i / W, c = i % W;
            drive(1'b1, 1'b0, pv(16'h20, r, c));
            errs   += bus.sof_err ? 1 : 0;
            starts += bus.start ? 1 : 0;
            tests++;
            if (bus.start !== (r >= 2 && c >= 2)) begin fails++; $display("FAIL midrst_start i=%0d got %b", i, bus.start); end
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    tests++;
                    if (pxa[k] !== pv(16'h20, r-2+k/3, c-2+k%3)) begin
                        fails++; $display("FAIL midrst_win r=%0d c=%0d k=%0d got %h exp %h", r, c, k, pxa[k], pv(16'h20, r-2+k/3, c-2+k%3));
                    end
                end
            end
        end
        tests++;
        if (errs != 0 || starts != 6) begin fails++; $display("FAIL midrst_count got err=%0d starts=%0d exp 0 6", errs, starts); end
    endtask

    task automatic test_reset_priority();
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'hFFFF);
        reset = 1'b1;
        tests++;
        if (bus.start !== 1'b0 || bus.px33 !== 16'h0) begin
            fails++; $display("FAIL rstprio_out got st=%b px33=%h exp 0 0000", bus.start, bus.px33);
        end
        // If the discarded pixel had been counted, every window below would be misaligned.
        for (int i = 0; i < W * H; i++) begin
            int r = i / W, c = i % W;
            drive(1'b1, 1'b0, pv(16'h60, r, c));
            tests++;
            if (bus.start !== (r >= 2 && c >= 2) || bus.sof_err !== 1'b0) begin
                fails++; $display("FAIL rstprio_start i=%0d got st=%b err=%b", i, bus.start, bus.sof_err);
            end
            if (r >= 2 && c >= 2) begin
                tests++;
                if (bus.px11 !== pv(16'h60, r-2, c-2) || bus.px33 !== pv(16'h60, r, c) || bus.ctr_col !== 3'(c-1)) begin
                    fails++; $display("FAIL rstprio_win r=%0d c=%0d got px11=%h px33=%h col=%0d", r, c, bus.px11, bus.px33, bus.ctr_col);
                end
            end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_in    = '0;
        test_reset();
        test_frame(1'b0);
        test_frame(1'b1);
        test_back_to_back();
        test_sof_restart();
        test_mid_reset();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Raster-to-window front end for the Sobel edge stage. It accepts one pixel per cycle in raster order, buffers the two previous image lines, and emits a registered 3x3 neighbourhood (px11..px33) with a one-cycle start strobe, which is exactly the input interface of the Sobel stage. Only fully populated windows are emitted; there is no border padding. It also reports the window-centre coordinates and a frame-done pulse.

Parameters:
DATA_W, 16, pixel width in bits; matches the Sobel stage port width
IMG_W, 640, pixels per line; must be at least 3
IMG_H, 480, lines per frame; must be at least 3
CW, $clog2(IMG_W), column counter width (derived; do not override)
RW, $clog2(IMG_H), row counter width (derived; do not override)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
pix_valid  in  1  pix_in is accepted this cycle; no backpressure
pix_sof  in  1  start of frame; qualified by pix_valid; marks the pixel at (0,0)
pix_in  in  DATA_W  input pixel
px11..px33  out  DATA_W each  window (9 ports); pxRC gives row R (1 = oldest line) and column C (1 = oldest, leftmost)
start  out  1  one-cycle pulse: window outputs are valid
ctr_row  out  RW  row of the window centre (px22)
ctr_col  out  CW  column of the window centre (px22)
frame_done  out  1  one-cycle pulse with the last window of a frame
sof_err  out  1  one-cycle pulse: pix_sof seen while not at (0,0)

Behaviour:
- Reset (reset low at a clock edge) clears the following: col_cnt, row_cnt, all px outputs, start, ctr_row, ctr_col, frame_done and sof_err. Line buffers are not cleared because their stale contents are never emitted.
- Accept occurs when pix_valid is 1. If pix_sof is also 1, the pixel is treated as (0,0). Counters are forced as though they were 0 before this pixel. sof_err pulses in the next cycle if the counters were not already at (0,0).
- Storage:
  - Line buffer lb1 holds the previous line; lb2 holds the line before that. Each is IMG_W deep, indexed by col_cnt.
  - On an accept at column c: lb2[c] <= lb1[c]; lb1[c] <= pix_in.
  - The window shifts left: column 1 <= column 2, column 2 <= column 3, new column 3 <= {row1 = lb2[c], row2 = lb1[c], row3 = pix_in}. The values used are the lb contents before the write.
- Counters:
  - col_cnt increments on each accept and wraps from IMG_W-1 to 0; row_cnt increments on that wrap.
  - After the accept at (IMG_H-1, IMG_W-1), both counters return to 0, so the next frame needs no pix_sof.
- Output timing:
  - start = 1 in the cycle after an accept at (r, c) with r >= 2 and c >= 2. In that same cycle, ctr_row = r-1 and ctr_col = c-1.
  - The window columns never straddle two lines, because start is suppressed for c < 2.
  - Latency is 1 cycle from the completing pixel to start.
- frame_done is asserted together with start when the window is completed by (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- Idle (pix_valid = 0): no state changes; start, frame_done and sof_err are 0; px outputs hold their last values.
- Gaps may occur anywhere, including mid-line; the output is identical to gap-free input apart from timing.
- Arithmetic: none on pixel data. Pixels pass through unchanged at DATA_W bits.
- Reset during a frame: the state is cleared and the next accepted pixel is (0,0). This applies whether or not pix_sof accompanies it, and no sof_err is raised.
- Reset takes priority over pix_valid in the same cycle.

Test Plan:
1. IMG_W=5, IMG_H=4, pixel = 16*row + col, continuous valid, pix_sof on the first pixel:
   - The first start comes one cycle after the pixel at (2,2), with px11=0x00, px12=0x01, px13=0x02, px21=0x10, px22=0x11, px23=0x12, px31=0x20, px32=0x21, px33=0x22, ctr=(1,1).
   - Exactly 6 start pulses occur, with centres (1,1), (1,2), (1,3), (2,1), (2,2), (2,3).
   - frame_done occurs only on the pulse with centre (2,3), and that window has px33=0x34.
2. Same stimulus as scenario 1 with pix_valid deasserted for 3 cycles after every second pixel -> the same 6 windows with the same values, each start exactly 1 cycle after its completing pixel, and px outputs held during gaps.
3. Two back-to-back frames, with pix_sof only on the first frame and the second frame's pixels offset by 0x80 -> 12 start pulses and 2 frame_done pulses, and the second frame's first window has px11=0x80 and px33=0xA2.
4. pix_sof asserted at (2,3) of frame 1:
   - sof_err pulses once.
   - That pixel becomes (0,0).
   - The next start follows pixel (2,2) of the restarted frame with ctr=(1,1).
5. reset pulled low for 1 cycle after the pixel at (3,1) -> all outputs are 0 the next cycle; new frame data without pix_sof is then processed from (0,0), with the first start after (2,2) and sof_err never asserted.
6. pix_valid and reset low in the same cycle -> the pixel is discarded, the counters stay at 0 and start stays 0.
